// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave with a fixed, parameterised response latency.
// Optional byte strobes (be_DMR) are enabled by defining DMR_BYTE_STROBE_EN.
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk_DMR,
  input  logic        rst_DMR_n,
  input  logic        req_DMR,
  input  logic        we_DMR,
  input  logic [31:0] addr_DMR,
  input  logic [31:0] wdata_DMR,
`ifdef DMR_BYTE_STROBE_EN
  input  logic [3:0]  be_DMR,
`endif
  output logic        ack_DMR,
  output logic [31:0] rdata_DMR,
  output logic        err_DMR,
  output logic        busy_DMR
);

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [DEPTH];

  logic          op_we, op_err, enter_resp, commit;
  logic [31:0]   op_addr, op_wdata, old_word, merged;
  logic [3:0]    op_be;
  logic [AW-1:0] op_idx;

`ifdef DMR_BYTE_STROBE_EN
  logic [3:0]    be_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req_DMR) begin
        cnt_d   = LAT;
        state_d = (LAT == 4'd0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero latency the op executes on the accepting edge, so take it straight from the port.
  always_comb begin
    op_we    = (state_q == IDLE) ? we_DMR    : we_q;
    op_addr  = (state_q == IDLE) ? addr_DMR  : addr_q;
    op_wdata = (state_q == IDLE) ? wdata_DMR : wdata_q;
`ifdef DMR_BYTE_STROBE_EN
    op_be    = (state_q == IDLE) ? be_DMR    : be_q;
`else
    op_be    = 4'hF;
`endif
  end

  assign op_idx     = op_addr[AW+1:2];
  assign op_err     = (|op_addr[1:0]) | (|op_addr[31:AW+2]);
  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign old_word   = mem_q[op_idx];
  assign commit     = enter_resp && rst_DMR_n && op_we && !op_err;

  always_comb begin
    merged = old_word;
    for (int b = 0; b < 4; b++)
      if (op_be[b]) merged[8*b +: 8] = op_wdata[8*b +: 8];
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d   = op_err;
      rdata_d = op_err ? 32'h0 : old_word;
    end
  end

  always_ff @(posedge clk_DMR) begin
    if (!rst_DMR_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request fields are latched only on acceptance, so later port activity is ignored.
  always_ff @(posedge clk_DMR) begin
    if (state_q == IDLE && req_DMR) begin
      we_q    <= we_DMR;
      addr_q  <= addr_DMR;
      wdata_q <= wdata_DMR;
`ifdef DMR_BYTE_STROBE_EN
      be_q    <= be_DMR;
`endif
    end
  end

  // Storage survives reset.
  always_ff @(posedge clk_DMR) begin
    if (commit) mem_q[op_idx] <= merged;
  end

  assign ack_DMR   = (state_q == RESP);
  assign busy_DMR  = (state_q != IDLE);
  assign rdata_DMR = rdata_q;
  assign err_DMR   = err_q;

endmodule
